// File: rtl/msm_pkg.sv
// msm_pkg: shared field width and issue-sequencer state encoding.
package msm_pkg;
    localparam int P_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, CLEAR, WAIT, HOLD} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head, power-of-two depth.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_ptr_q] <= din;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mod_mul_issue.sv
// mod_mul_issue: buffers tagged operand pairs and sequences an external ModMul
// through clear / compute / hold, with a per-operation watchdog.
module mod_mul_issue #(
    parameter int P_WIDTH = msm_pkg::P_WIDTH,
    parameter int TAG_W   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P_WIDTH-1:0] in_a,
    input  logic [P_WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic [P_WIDTH-1:0] mm_a,
    output logic [P_WIDTH-1:0] mm_b,
    output logic               mm_enable,
    output logic               mm_reset,
    input  logic [P_WIDTH-1:0] mm_r,
    input  logic               mm_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] out_r,
    output logic [TAG_W-1:0]   out_tag,
    output logic               err_timeout
);
    import msm_pkg::*;
    localparam int EW = 2*P_WIDTH + TAG_W;
    localparam int CW = $clog2(TIMEOUT);
    state_e               state_q;
    logic [P_WIDTH-1:0]   a_q, b_q, r_q;
    logic [TAG_W-1:0]     tag_q, otag_q;
    logic                 en_q, mmrst_q, ov_q, err_q, rdy_q;
    logic [CW-1:0]        cnt_q;
    logic [EW-1:0]        fifo_head;
    logic                 fifo_full, fifo_empty, pop, timeout_hit, advance;
    logic [$clog2(DEPTH):0] fifo_count;
    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .pop     (pop),
        .din     ({in_a, in_b, in_tag}),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
    // in_ready depends only on registered state, so a pop this cycle never frees a slot early
    assign in_ready    = rdy_q && !fifo_full;
    assign timeout_hit = state_q == WAIT && !mm_done && cnt_q == CW'(TIMEOUT-1);
    assign advance     = (state_q == HOLD && out_ready) || timeout_hit;
    assign pop         = (state_q == IDLE && !fifo_empty) || (advance && fifo_count != '0);
    assign mm_a        = a_q;
    assign mm_b        = b_q;
    assign mm_enable   = en_q;
    assign mm_reset    = !reset_n || mmrst_q;
    assign out_valid   = ov_q;
    assign out_r       = r_q;
    assign out_tag     = otag_q;
    assign err_timeout = err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            tag_q   <= '0;
            otag_q  <= '0;
            en_q    <= 1'b0;
            mmrst_q <= 1'b0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (pop) {a_q, b_q, tag_q} <= fifo_head;
            case (state_q)
                IDLE: begin
                    state_q <= pop ? CLEAR : IDLE;
                    mmrst_q <= pop;
                end
                CLEAR: begin
                    state_q <= WAIT;
                    mmrst_q <= 1'b0;
                    en_q    <= 1'b1;
                    cnt_q   <= '0;
                end
                WAIT:
                    if (mm_done) begin
                        r_q     <= mm_r;
                        otag_q  <= tag_q;
                        en_q    <= 1'b0;
                        ov_q    <= 1'b1;
                        state_q <= HOLD;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        en_q    <= 1'b0;
                        state_q <= pop ? CLEAR : IDLE;
                        mmrst_q <= pop;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                HOLD:
                    if (out_ready) begin
                        ov_q    <= 1'b0;
                        state_q <= pop ? CLEAR : IDLE;
                        mmrst_q <= pop;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_mul_issue.sv
// tb_mod_mul_issue: directed checks of the issue sequencer against a 10-cycle mod-97 ModMul stub.
module tb_mod_mul_issue;
    localparam int PW = 16;
    localparam int TW = 8;
    logic clk, reset_n, in_valid, in_ready, mm_enable, mm_reset, mm_done;
    logic out_valid, out_ready, err_timeout, hang, force_done, go;
    logic [PW-1:0] in_a, in_b, mm_a, mm_b, mm_r, out_r;
    logic [TW-1:0] in_tag, out_tag;
    logic [7:0] stub_cnt;
    logic [15:0] a_t [0:31];
    logic [15:0] b_t [0:31];
    logic [15:0] exp_r [0:31];
    int vectors, miscompares, i, rx, n, n_en, drop_at;
    logic seen;

    mod_mul_issue #(.P_WIDTH(PW), .TAG_W(TW), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .mm_a(mm_a), .mm_b(mm_b),
        .mm_enable(mm_enable), .mm_reset(mm_reset), .mm_r(mm_r), .mm_done(mm_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (mm_reset) stub_cnt <= 8'd0;
        else if (mm_enable && stub_cnt < 8'd10) stub_cnt <= stub_cnt + 8'd1;
    assign mm_done = force_done || (!hang && stub_cnt == 8'd10);
    assign mm_r    = PW'((32'(mm_a) * 32'(mm_b)) % 32'd97);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int t);
        in_a   = a_t[t];
        in_b   = b_t[t];
        in_tag = TW'(t);
    endtask

    task automatic push_op(input int t);
        set_op(t);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) tick;
        chk("push_rdy", 32'(in_ready), 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cnt, input int t0);
        int got;
        got = 0;
        for (int c = 0; c < 300 && got < cnt; c++) begin
            if (out_valid) begin
                chk("drain_tag", 32'(out_tag), 32'(t0 + got));
                chk("drain_r", 32'(out_r), 32'(exp_r[t0 + got]));
                got++;
            end
            tick;
        end
        chk("drain_cnt", 32'(got), 32'(cnt));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        for (int k = 0; k < 32; k++) begin a_t[k] = 16'd1; b_t[k] = 16'd1; exp_r[k] = 16'd1; end
        a_t[7]  = 50; b_t[7]  = 3;  exp_r[7]  = 53;
        a_t[0]  = 10; b_t[0]  = 20; exp_r[0]  = 6;
        a_t[1]  = 33; b_t[1]  = 44; exp_r[1]  = 94;
        a_t[2]  = 96; b_t[2]  = 96; exp_r[2]  = 1;
        a_t[3]  = 0;  b_t[3]  = 55; exp_r[3]  = 0;
        a_t[4]  = 12; b_t[4]  = 13; exp_r[4]  = 59;
        a_t[5]  = 90; b_t[5]  = 2;  exp_r[5]  = 83;
        a_t[8]  = 7;  b_t[8]  = 9;  exp_r[8]  = 63;
        a_t[9]  = 5;  b_t[9]  = 5;  exp_r[9]  = 25;
        a_t[10] = 20; b_t[10] = 10; exp_r[10] = 6;
        a_t[11] = 50; b_t[11] = 50; exp_r[11] = 75;
        a_t[12] = 3;  b_t[12] = 4;  exp_r[12] = 12;
        a_t[13] = 2;  b_t[13] = 3;  exp_r[13] = 6;
        a_t[14] = 4;  b_t[14] = 5;  exp_r[14] = 20;
        a_t[15] = 1;  a_t[16] = 2;  a_t[17] = 3;  a_t[18] = 4;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hang = 1'b0; force_done = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        tick; tick; tick;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mm_reset", 32'(mm_reset), 1);
        chk("rst_mm_enable", 32'(mm_enable), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_out_r", 32'(out_r), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_mm_a", 32'(mm_a), 0);
        reset_n = 1'b1;
        tick;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_mm_reset", 32'(mm_reset), 0);

        // single operation and latency
        out_ready = 1'b1;
        set_op(7); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("idle_mm_reset", 32'(mm_reset), 0);
        tick;
        chk("clear_mm_reset", 32'(mm_reset), 1);
        chk("clear_mm_enable", 32'(mm_enable), 0);
        tick;
        chk("wait_mm_enable", 32'(mm_enable), 1);
        chk("wait_mm_a", 32'(mm_a), 50);
        chk("wait_mm_b", 32'(mm_b), 3);
        n = 2;
        while (!out_valid && n < 40) begin tick; n++; end
        chk("single_latency", 32'(n), 13);
        chk("single_r", 32'(out_r), 53);
        chk("single_tag", 32'(out_tag), 7);
        tick;
        chk("single_valid_drop", 32'(out_valid), 0);

        // stray done while idle
        force_done = 1'b1;
        tick; tick;
        force_done = 1'b0;
        chk("stray_idle_en", 32'(mm_enable), 0);
        chk("stray_idle_rst", 32'(mm_reset), 0);
        chk("stray_idle_valid", 32'(out_valid), 0);
        chk("stray_idle_r", 32'(out_r), 53);

        // back-to-back six operations
        i = 0; rx = 0; drop_at = -1;
        for (int c = 0; c < 300 && rx < 6; c++) begin
            if (out_valid) begin
                chk("b2b_tag", 32'(out_tag), 32'(rx));
                chk("b2b_r", 32'(out_r), 32'(exp_r[rx]));
                rx++;
            end
            if (!in_ready && drop_at < 0 && i < 6) drop_at = i;
            in_valid = i < 6;
            if (i < 6) set_op(i);
            go = in_valid && in_ready;
            tick;
            if (go) i++;
        end
        in_valid = 1'b0;
        chk("b2b_results", 32'(rx), 6);
        chk("b2b_pushes", 32'(i), 6);
        chk("b2b_drop_at", 32'(drop_at), 5);

        // backpressure in HOLD while the FIFO fills
        out_ready = 1'b0;
        push_op(8);
        n = 0;
        while (!out_valid && n < 40) begin tick; n++; end
        chk("bp_valid", 32'(out_valid), 1);
        i = 9;
        for (int c = 0; c < 20; c++) begin
            chk("bp_r", 32'(out_r), 63);
            chk("bp_tag", 32'(out_tag), 8);
            chk("bp_mm_reset", 32'(mm_reset), 0);
            in_valid = i < 13;
            if (i < 13) set_op(i);
            go = in_valid && in_ready;
            force_done = c == 5;
            tick;
            if (go) i++;
        end
        in_valid = 1'b0; force_done = 1'b0;
        chk("bp_full", 32'(in_ready), 0);
        chk("bp_pushes", 32'(i), 13);
        chk("bp_still_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        drain(5, 8);

        // timeout then normal completion
        hang = 1'b1;
        push_op(13);
        push_op(14);
        n_en = 0; seen = 1'b0;
        for (int c = 0; c < 100 && !err_timeout; c++) begin
            if (mm_enable) n_en++;
            if (out_valid) seen = 1'b1;
            tick;
        end
        hang = 1'b0;
        chk("to_err", 32'(err_timeout), 1);
        chk("to_wait_cycles", 32'(n_en), 16);
        chk("to_no_valid", 32'(seen), 0);
        drain(1, 14);
        chk("to_err_sticky", 32'(err_timeout), 1);

        // reset mid-WAIT with three entries queued
        hang = 1'b1;
        push_op(15); push_op(16); push_op(17); push_op(18);
        tick; tick;
        chk("mid_wait_en", 32'(mm_enable), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_mm_reset", 32'(mm_reset), 1);
        chk("mid_rst_en", 32'(mm_enable), 0);
        chk("mid_rst_mm_a", 32'(mm_a), 0);
        chk("mid_rst_mm_b", 32'(mm_b), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_err", 32'(err_timeout), 0);
        chk("mid_rst_out_r", 32'(out_r), 0);
        chk("mid_rst_out_tag", 32'(out_tag), 0);
        tick; tick;
        reset_n = 1'b1; hang = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid || mm_enable) seen = 1'b1;
            tick;
        end
        chk("post_rst_quiet", 32'(seen), 0);
        chk("post_rst_ready", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mod_mul_issue.md
MOD_MUL_ISSUE -- requirements
Module: mod_mul_issue

Interface
REQ-001 SHALL have parameter P_WIDTH, default msm_pkg::P_WIDTH, meaning field element width.
REQ-002 SHALL have parameter TAG_W, default 8, meaning width of the caller's operation tag.
REQ-003 SHALL have parameter DEPTH, default 4, meaning operand FIFO depth (power of two, at least 2).
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of WAIT cycles allowed per operation.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, operand pair valid.
REQ-008 SHALL have port in_ready, output, 1, FIFO can accept.
REQ-009 SHALL have ports in_a and in_b, input, P_WIDTH, carrying the operands.
REQ-010 SHALL have port in_tag, input, TAG_W, carrying the operation tag.
REQ-011 SHALL have ports mm_a and mm_b, output, P_WIDTH, driving the ModMul operands.
REQ-012 SHALL have port mm_enable, output, 1, the ModMul enable.
REQ-013 SHALL have port mm_reset, output, 1, the active-high ModMul reset.
REQ-014 SHALL have port mm_r, input, P_WIDTH, the ModMul remainder.
REQ-015 SHALL have port mm_done, input, 1, the ModMul done.
REQ-016 SHALL have port out_valid, output, 1, result valid.
REQ-017 SHALL have port out_ready, input, 1, downstream accepts.
REQ-018 SHALL have port out_r, output, P_WIDTH, the result.
REQ-019 SHALL have port out_tag, output, TAG_W, the result tag.
REQ-020 SHALL have port err_timeout, output, 1, a sticky timeout flag.

Function
REQ-021 SHALL push {a,b,tag} on in_valid&&in_ready; in_ready = !full, computed from registered state only, so a same-cycle pop does not free a slot.
REQ-022 SHALL use FSM states IDLE, CLEAR, WAIT, HOLD.
REQ-023 IDLE SHALL go to CLEAR when the FIFO is non-empty, popping the head into registered mm_a, mm_b and tag on that edge.
REQ-024 CLEAR SHALL last exactly one cycle with mm_reset=1 and mm_enable=0, then go to WAIT.
REQ-025 WAIT SHALL hold mm_enable=1 and keep mm_a/mm_b stable; on mm_done=1 it SHALL capture mm_r into out_r and the tag into out_tag, then go to HOLD.
REQ-026 HOLD SHALL assert out_valid with out_r and out_tag stable; on out_ready it SHALL go to CLEAR (popping the next entry) when the FIFO is non-empty, else to IDLE.
REQ-027 mm_done SHALL be ignored outside WAIT.
REQ-028 A WAIT cycle counter SHALL clear on entry to WAIT; when it reaches TIMEOUT-1 without mm_done, err_timeout SHALL set, the operation SHALL be dropped with no out_valid, and the FSM SHALL go to CLEAR when the FIFO is non-empty, else to IDLE.
REQ-029 err_timeout SHALL stay set until reset.
REQ-030 With the FIFO empty and the FSM in IDLE, a push in cycle N SHALL give CLEAR at N+1 and WAIT at N+2; out_valid SHALL rise the cycle after mm_done.
REQ-031 Results SHALL emerge in acceptance order.
REQ-032 Pushes SHALL continue while the FSM is in WAIT or HOLD until the FIFO is full.

Reset
REQ-033 While reset_n=0, the block SHALL clear the FIFO pointers and count, set the FSM to IDLE, and drive in_ready=0, out_valid=0, out_r=0, out_tag=0, mm_a=0, mm_b=0, mm_enable=0, err_timeout=0, and the counter to 0.
REQ-034 mm_reset SHALL be 1 while reset_n=0 and SHALL otherwise be 1 only in CLEAR.
REQ-035 A reset asserted mid-operation SHALL abort the operation, discarding the FIFO contents and any pending result.
REQ-036 in_ready SHALL rise in the first cycle after reset_n deasserts.

Structure
REQ-037 P_WIDTH and the FSM state enum SHALL live in msm_pkg.
REQ-038 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width and depth, with full, empty and count outputs), instantiated once.

Verification
REQ-039 Single operation: ModMul stub with 10-cycle latency and p=97; push a=50, b=3, tag=7 -> out_r=53, out_tag=7; out_valid rises 13 cycles after the push.
REQ-040 Back-to-back: push 6 operations with tags 0..5 and out_ready=1 -> in_ready drops after 4 buffered entries; all 6 results emerge in tag order with correct products mod 97.
REQ-041 Backpressure: out_ready=0 for 20 cycles in HOLD -> out_r and out_tag stay stable, no mm_reset, and the FIFO fills to full.
REQ-042 Timeout: stub never asserts done, TIMEOUT=16 -> err_timeout=1 after 16 WAIT cycles, no out_valid, and the next queued operation completes normally.
REQ-043 Reset mid-WAIT: reset_n=0 for 2 cycles with 3 entries queued -> all outputs zero, mm_reset=1, and no result emerges afterwards.
REQ-044 Stray done: mm_done pulsed in IDLE and in HOLD -> no state change and no data change.
